// File: rtl/mips_alu_seq.sv
// Registered MIPS R-type ALU for the EX stage. Single-cycle ops return after one edge.
// MULT/DIV use an iterative shift-add / restoring-divide unit with HI/LO registers.
module mips_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       func,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             out_valid,
  output logic             ovf,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_nxt;

  logic             accept, is_md;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] m, ph, pl;
  logic             is_div, neg_q, neg_r, div0;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_md    = (func == F_MULT) || (func == F_MULTU) || (func == F_DIV) || (func == F_DIVU);

  // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_md) state_nxt = RUN;
      RUN:     if (cnt == LAST_STEP) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle result path
  logic [SHW-1:0]   sa;
  logic [WIDTH-1:0] sum, diff, sc_d;
  logic             sc_ovf, sc_ill, sc_wd;

  assign sa   = func[2] ? B[SHW-1:0] : shamt;
  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    sc_d   = '0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    sc_wd  = 1'b1;
    case (func)
      F_SLL, F_SLLV: sc_d = A << sa;
      F_SRL, F_SRLV: sc_d = A >> sa;
      F_SRA, F_SRAV: sc_d = $unsigned($signed(A) >>> sa);
      F_ADD: begin
        sc_d   = sum;
        sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      F_ADDU: sc_d = sum;
      F_SUB: begin
        sc_d   = diff;
        sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      F_SUBU: sc_d = diff;
      F_AND:  sc_d = A & B;
      F_OR:   sc_d = A | B;
      F_XOR:  sc_d = A ^ B;
      F_NOR:  sc_d = ~(A | B);
      F_SLT:  sc_d = WIDTH'($signed(A) < $signed(B));
      F_SLTU: sc_d = WIDTH'(A < B);
      F_MFHI: sc_d = hi;
      F_MFLO: sc_d = lo;
      F_MTHI, F_MTLO: sc_wd = 1'b0;
      default: sc_ill = 1'b1;
    endcase
  end

  // Operand magnitudes for the signed multiply/divide
  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign sgn   = ~func[0];
  assign a_neg = sgn & A[WIDTH-1];
  assign b_neg = sgn & B[WIDTH-1];
  assign a_mag = a_neg ? (~A + 1'b1) : A;
  assign b_mag = b_neg ? (~B + 1'b1) : B;

  // One iteration step. The remainder stays below the divisor, so bit WIDTH of the
  // trial difference is a clean borrow.
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] hi_fix, lo_fix;

  assign mul_sum  = {1'b0, ph} + (pl[0] ? {1'b0, m} : '0);
  assign div_sh   = {ph, pl[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, m};
  assign prod     = {ph, pl};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;

  always_comb begin
    hi_fix = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix = prod_fix[WIDTH-1:0];
    if (is_div) begin
      hi_fix = neg_r ? (~ph + 1'b1) : ph;
      lo_fix = div0 ? '1 : (neg_q ? (~pl + 1'b1) : pl);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      m         <= '0;
      ph        <= '0;
      pl        <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      D         <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && is_md) begin
            cnt    <= '0;
            is_div <= func[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= (B == '0);
            ph     <= '0;
            m      <= func[1] ? b_mag : a_mag;
            pl     <= func[1] ? a_mag : b_mag;
          end else if (accept) begin
            out_valid <= 1'b1;
            ovf       <= sc_ovf;
            illegal   <= sc_ill;
            if (sc_wd) D <= sc_d;
            if (func == F_MTHI) hi <= A;
            if (func == F_MTLO) lo <= A;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              ph <= div_diff[WIDTH-1:0];
              pl <= {pl[WIDTH-2:0], 1'b1};
            end else begin
              ph <= div_sh[WIDTH-1:0];
              pl <= {pl[WIDTH-2:0], 1'b0};
            end
          end else begin
            {ph, pl} <= {mul_sum, pl[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi        <= hi_fix;
          lo        <= lo_fix;
          D         <= lo_fix;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_seq.sv
// Directed self-checking bench for mips_alu_seq at WIDTH=32: a vector table for the
// single-cycle ops plus hand-written multiply/divide, handshake and reset sequences.
module tb_mips_alu_seq;

  logic        clk, rst_n, in_valid, in_ready;
  logic [5:0]  func;
  logic [4:0]  shamt;
  logic [31:0] A, B, D, hi, lo;
  logic        out_valid, ovf, illegal;

  int checks = 0;
  int errors = 0;

  mips_alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .shamt(shamt), .A(A), .B(B), .D(D), .out_valid(out_valid),
    .ovf(ovf), .illegal(illegal), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic [4:0]  sh;
    logic [31:0] a, b, d;
    logic        ovf, ill;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one op on the falling edge; return 1 ns after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] a, b);
    @(negedge clk);
    func = f; shamt = sh; A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_single(input string name, input logic [5:0] f, input logic [4:0] sh,
                            input logic [31:0] a, b, d, input logic eo, ei);
    issue(f, sh, a, b);
    check({name, ".valid"}, out_valid, 1);
    check({name, ".D"}, D, d);
    check({name, ".ovf"}, ovf, eo);
    check({name, ".illegal"}, illegal, ei);
  endtask

  // Multi-cycle op. For the first 'hold' edges after accept an ADD request is held on
  // in_valid to show it is ignored while busy.
  task automatic run_multi(input string name, input logic [5:0] f, input logic [31:0] a, b,
                           input logic [31:0] ehi, elo, input int hold);
    int n = 0;
    bit early = 0;
    issue(f, 5'd0, a, b);
    check({name, ".busy"}, in_ready, 0);
    if (hold > 0) begin
      func = 6'h20; in_valid = 1'b1;
    end
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n >= hold) in_valid = 1'b0;
      if (out_valid) break;
      if (in_ready) early = 1;
    end
    check({name, ".latency"}, n, 33);
    check({name, ".ready_low"}, early, 0);
    check({name, ".hi"}, hi, ehi);
    check({name, ".lo"}, lo, elo);
    check({name, ".D"}, D, elo);
    check({name, ".ready_after"}, in_ready, 1);
    @(posedge clk);
    #1;
    check({name, ".single_pulse"}, out_valid, 0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; func = '0; shamt = '0; A = '0; B = '0;

    tbl.push_back('{"add_ovf",  6'h20, 5'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 1'b0});
    tbl.push_back('{"addu",     6'h21, 5'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0});
    tbl.push_back('{"sub",      6'h22, 5'd0, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0});
    tbl.push_back('{"sub_ovf",  6'h22, 5'd0, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b0});
    tbl.push_back('{"subu",     6'h23, 5'd0, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0});
    tbl.push_back('{"sra",      6'h03, 5'd4, 32'h80000010, 32'h0,        32'hF8000001, 1'b0, 1'b0});
    tbl.push_back('{"srl",      6'h02, 5'd4, 32'h80000010, 32'h0,        32'h08000001, 1'b0, 1'b0});
    tbl.push_back('{"sll",      6'h00, 5'd4, 32'h80000010, 32'h0,        32'h00000100, 1'b0, 1'b0});
    tbl.push_back('{"sllv",     6'h04, 5'd9, 32'h1,        32'h25,       32'h00000020, 1'b0, 1'b0});
    tbl.push_back('{"srav",     6'h07, 5'd0, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0});
    tbl.push_back('{"srlv",     6'h06, 5'd0, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0});
    tbl.push_back('{"and",      6'h24, 5'd0, 32'hF0F0,     32'hFF00,     32'h0000F000, 1'b0, 1'b0});
    tbl.push_back('{"or",       6'h25, 5'd0, 32'hF0F0,     32'hFF00,     32'h0000FFF0, 1'b0, 1'b0});
    tbl.push_back('{"xor",      6'h26, 5'd0, 32'hF0F0,     32'hFF00,     32'h00000FF0, 1'b0, 1'b0});
    tbl.push_back('{"nor",      6'h27, 5'd0, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0});
    tbl.push_back('{"illegal",  6'h3F, 5'd0, 32'h1234,     32'h5678,     32'h00000000, 1'b0, 1'b1});
    tbl.push_back('{"slt",      6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h00000001, 1'b0, 1'b0});
    tbl.push_back('{"sltu",     6'h2B, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b0, 1'b0});

    #12;
    check("rst.D", D, 0);
    check("rst.hi", hi, 0);
    check("rst.lo", lo, 0);
    check("rst.valid", out_valid, 0);
    check("rst.ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      run_single(tbl[i].name, tbl[i].f, tbl[i].sh, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].ovf, tbl[i].ill);
    @(posedge clk);
    #1;
    check("idle.valid_low", out_valid, 0);

    run_multi("mult",  6'h18, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    run_multi("multu", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_multi("div",   6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_multi("div_mn",6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run_multi("divu0", 6'h1B, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 0);
    run_single("mfhi", 6'h10, 5'd0, 32'h0, 32'h0, 32'd7, 1'b0, 1'b0);
    run_multi("div_busy", 6'h1A, 32'd100, 32'd7, 32'd2, 32'd14, 10);

    // MTLO leaves D at the previous quotient
    run_single("mtlo", 6'h13, 5'd0, 32'h1234, 32'h0, 32'd14, 1'b0, 1'b0);
    check("mtlo.lo", lo, 32'h1234);
    run_single("mflo", 6'h12, 5'd0, 32'h0, 32'h0, 32'h1234, 1'b0, 1'b0);
    run_single("mthi", 6'h11, 5'd0, 32'hABCD, 32'h0, 32'h1234, 1'b0, 1'b0);
    run_single("mfhi2", 6'h10, 5'd0, 32'h0, 32'h0, 32'hABCD, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.D", D, 0);
    check("arst.hi", hi, 0);
    check("arst.lo", lo, 0);
    check("arst.ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while a multiply is iterating
    run_single("mthi3", 6'h11, 5'd0, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(6'h18, 5'd0, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.hi", hi, 0);
    check("abort.lo", lo, 0);
    check("abort.valid", out_valid, 0);
    check("abort.ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("abort.no_result", seen, 0);
    check("abort.lo_after", lo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_alu_seq.md
Name: mips_alu_seq

Overview:
- Parametrised, registered successor of the single-cycle MIPS R-type ALU.
- Executes all R-type ALU functions with one-cycle registered latency.
- Adds an iterative multiply/divide unit with HI/LO registers, MFHI/MTHI/MFLO/MTLO, true arithmetic right shift, unsigned SLTU, signed-overflow flag and a valid/ready handshake.
- Sits in the EX stage; the stall logic uses in_ready.

Parameters:
- WIDTH, 32: datapath width. Must be a power of two, 8..64.
- SHW, $clog2(WIDTH): shift-amount width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  high when an operation can be accepted
- func  in  6  MIPS funct field
- shamt  in  SHW  immediate shift amount
- A  in  WIDTH  rs operand
- B  in  WIDTH  rt operand
- D  out  WIDTH  registered result
- out_valid  out  1  one-cycle pulse, D/flags valid
- ovf  out  1  signed overflow of ADD/SUB, qualified by out_valid
- illegal  out  1  unsupported func, qualified by out_valid
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: rst_n low clears all of the following asynchronously to 0: D, out_valid, ovf, illegal, hi, lo, iteration counter and internal registers. State goes to IDLE.
- Reset mid multiply/divide aborts the operation. HI/LO read 0.
- Accept: an operation is accepted on a rising edge with in_valid=1 and in_ready=1. in_ready = (state==IDLE). in_valid while busy is ignored; no queuing.
- Single-cycle ops: accepted at edge k, D/out_valid are visible after edge k. out_valid is low every other cycle unless a new op is accepted.
  - 0x00 SLL A<<shamt; 0x02 SRL A>>shamt, zero-fill; 0x03 SRA A>>shamt, sign-fill.
  - 0x04/0x06/0x07 same three shifts by B[SHW-1:0].
  - 0x20 ADD and 0x21 ADDU: A+B mod 2^WIDTH. 0x22 SUB and 0x23 SUBU: A-B mod 2^WIDTH.
  - ovf=1 only for ADD/SUB on signed overflow. D is written anyway; there is no trap.
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR.
  - 0x2A SLT: signed A<B gives 1, else 0. 0x2B SLTU: unsigned compare.
  - 0x10 MFHI D=hi; 0x12 MFLO D=lo.
  - 0x11 MTHI hi<=A; 0x13 MTLO lo<=A. D is unchanged; out_valid still pulses.
  - Any other func: D=0, illegal=1 for that pulse.
- Multi-cycle ops: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
  - FSM states: IDLE -> RUN -> FIX -> IDLE.
  - On accept: latch operands, converted to magnitudes for the signed ops, and record the result signs. Counter=0, state RUN.
  - RUN: one shift-add (multiply) or one restoring-subtract (divide) step per cycle. Exactly WIDTH cycles, then FIX.
  - FIX, one cycle: apply sign correction and write hi/lo. out_valid=1, D=lo. Return to IDLE.
  - out_valid is visible WIDTH+1 edges after the accept edge: 33 for WIDTH=32.
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: lo = all ones, hi = A. No exception.
  - DIV of most-negative by -1: lo = most-negative, hi = 0.
  - hi/lo are unchanged during RUN and change only in FIX or on MTHI/MTLO.
- Back-to-back: in_ready rises the cycle after FIX, so a new op can be accepted on the edge immediately following out_valid.

Test Plan:
1. Reset with rst_n=0 asserted asynchronously mid-cycle -> D, hi, lo, out_valid read 0 immediately and in_ready=1. Repeat during MULT RUN -> the operation is aborted and hi=lo=0.
2. ADD A=0x7FFFFFFF, B=1 -> D=0x80000000, ovf=1. ADDU with the same operands -> same D, ovf=0. SUB 5-7 -> D=0xFFFFFFFE.
3. SRA A=0x80000010, shamt=4 -> D=0xF8000001. SRL with the same operands -> D=0x08000001. SLT A=0xFFFFFFFF, B=1 -> D=1. SLTU with the same operands -> D=0.
4. MULT A=0xFFFFFFFE (-2), B=3 -> in_ready low for 33 cycles, out_valid at edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
5. DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7. Then MFHI -> D=7 with 1-cycle latency.
6. in_valid held high with an ADD during a DIV RUN -> not accepted and no extra out_valid. MTLO A=0x1234 then MFLO -> D=0x1234. func=0x3F -> illegal=1, D=0.
